// File: rtl/cp0_exc_ctrl_if.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl_if
// Bundle of the M-stage signals exchanged between the pipeline and the
// coprocessor-0 exception controller.
//   master : pipeline side; drives the CP0 access (a, din, we), the M-stage
//            instruction context (M_pc, M_exccode, bd, eret) and the
//            external interrupt lines (hwint); receives req, epc_out, dout.
//   slave  : cp0_exc_ctrl side, the mirror image of master.
// ---------------------------------------------------------------------------
interface cp0_exc_ctrl_if #(
    parameter int HWINT_W = 6
);
    logic [4:0]         a;
    logic [31:0]        din;
    logic               we;
    logic [31:0]        M_pc;
    logic [4:0]         M_exccode;
    logic               bd;
    logic               eret;
    logic [HWINT_W-1:0] hwint;
    logic               req;
    logic [31:0]        epc_out;
    logic [31:0]        dout;

    modport master (
        output a, din, we, M_pc, M_exccode, bd, eret, hwint,
        input  req, epc_out, dout
    );

    modport slave (
        input  a, din, we, M_pc, M_exccode, bd, eret, hwint,
        output req, epc_out, dout
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl
// Coprocessor-0 exception controller sitting at the M stage. It decides,
// combinationally, whether the M instruction or a pending hardware interrupt
// is taken (req), records SR/Cause/EPC on the following edge, and serves
// mfc0/mtc0/eret.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : cp0_exc_ctrl_if.slave
//              a/din/we        mfc0/mtc0 register number, write data, enable
//              M_pc/M_exccode  PC and exception code of the M instruction
//              bd              M instruction is in a branch delay slot
//              eret            eret in M
//              hwint           level-sensitive external interrupt lines
//              req             take exception: flush + redirect to 0x4180
//              epc_out         EPC with mtc0 bypass, used as eret target
//              dout            mfc0 read data
//
// Build option:
//   CP0_BD_EN  when defined, bd is captured into Cause.BD and delay-slot
//              victims record EPC = M_pc - 4. When undefined, bd is ignored,
//              Cause.BD reads 0 and EPC always records M_pc.
// ---------------------------------------------------------------------------
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID    = 32'h2021_0001,
    parameter int          HWINT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    cp0_exc_ctrl_if.slave   bus
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // Architectural state, stored only in the implemented fields.
    logic [HWINT_W-1:0] sr_im_q,     sr_im_d;
    logic               sr_exl_q,    sr_exl_d;
    logic               sr_ie_q,     sr_ie_d;
    logic               cause_bd_q,  cause_bd_d;
    logic [HWINT_W-1:0] cause_ip_q,  cause_ip_d;
    logic [4:0]         cause_exc_q, cause_exc_d;
    logic [29:0]        epc_q,       epc_d;

    logic        int_req;
    logic        exc_req;
    logic        take;
    logic [4:0]  sel_code;
    logic        bd_eff;
    logic [31:0] victim_pc;
    logic        mtc0_sr;
    logic        mtc0_epc;

`ifdef CP0_BD_EN
    logic [1:0] unused_pc_bits;
    assign bd_eff         = bus.bd;
    assign unused_pc_bits = victim_pc[1:0];
`else
    logic [2:0] unused_pc_bits;
    assign bd_eff         = 1'b0;
    assign unused_pc_bits = {victim_pc[1:0], bus.bd};
`endif

    // Request decision. The reset term keeps req low during reset even when
    // an exception code is sitting in M, since the flops alone only clear
    // EXL/IE and would not stop a synchronous exception.
    always_comb begin
        int_req   = (|(bus.hwint & sr_im_q)) & sr_ie_q & ~sr_exl_q;
        exc_req   = (bus.M_exccode != 5'd0) & ~sr_exl_q;
        take      = reset & (int_req | exc_req);
        sel_code  = int_req ? 5'd0 : bus.M_exccode;
        victim_pc = bd_eff ? (bus.M_pc - 32'd4) : bus.M_pc;
        mtc0_sr   = bus.we & (bus.a == ADDR_SR);
        mtc0_epc  = bus.we & (bus.a == ADDR_EPC);
    end

    // Next-state computation. Taking an exception overrides any mtc0/eret in
    // the same cycle. Otherwise mtc0 is applied first and eret clears EXL
    // afterwards, so an eret paired with an SR write still leaves EXL = 0.
    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = bus.hwint;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;

        if (take) begin
            sr_exl_d    = 1'b1;
            cause_exc_d = sel_code;
            cause_bd_d  = bd_eff;
            epc_d       = victim_pc[31:2];
        end else begin
            if (mtc0_sr) begin
                sr_im_d  = bus.din[15:10];
                sr_exl_d = bus.din[1];
                sr_ie_d  = bus.din[0];
            end
            if (mtc0_epc) begin
                epc_d = bus.din[31:2];
            end
            if (bus.eret) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= 5'd0;
            epc_q       <= 30'd0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    // Outputs. epc_out forwards an in-flight mtc0 EPC so that an eret in the
    // very next cycle already returns to the new address; dout has no bypass.
    always_comb begin
        bus.req     = take;
        bus.epc_out = (mtc0_epc & ~take) ? {bus.din[31:2], 2'b00}
                                         : {epc_q, 2'b00};
        case (bus.a)
            ADDR_SR:    bus.dout = {16'h0000, sr_im_q, 8'h00, sr_exl_q, sr_ie_q};
            ADDR_CAUSE: bus.dout = {cause_bd_q, 15'h0000, cause_ip_q, 3'b000,
                                    cause_exc_q, 2'b00};
            ADDR_EPC:   bus.dout = {epc_q, 2'b00};
            ADDR_PRID:  bus.dout = PRID;
            default:    bus.dout = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp0_exc_ctrl
// Self-checking bench for cp0_exc_ctrl: a directed vector table walking
// through exception, interrupt priority, delay slot, bypass and
// simultaneous-event cases, hand-written reset sequences, and a randomized
// phase compared against a word-level model of the CP0 registers.
// Honours CP0_BD_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID_VAL = 32'h2021_0001;
`ifdef CP0_BD_EN
    localparam logic [31:0] EPC_DS   = 32'h0000_301C;
    localparam logic [31:0] CAUSE_DS = 32'h8000_0030;
    localparam bit          BD_ON    = 1'b1;
`else
    localparam logic [31:0] EPC_DS   = 32'h0000_3020;
    localparam logic [31:0] CAUSE_DS = 32'h0000_0030;
    localparam bit          BD_ON    = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] din;
        logic        we;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic        bd;
        logic        eret;
        logic [5:0]  hwint;
        logic        exp_req;
        logic [31:0] exp_dout;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vecs[27];

    // Word-level model of SR, Cause and EPC.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    function automatic vec_t mk(input logic [4:0] a, input logic [31:0] din,
                                input logic we, input logic [31:0] pc,
                                input logic [4:0] exc, input logic bd,
                                input logic eret, input logic [5:0] hw,
                                input logic rq, input logic [31:0] dout,
                                input logic [31:0] epc);
        vec_t v;
        v.a = a; v.din = din; v.we = we; v.pc = pc; v.exc = exc; v.bd = bd;
        v.eret = eret; v.hwint = hw; v.exp_req = rq; v.exp_dout = dout;
        v.exp_epc = epc;
        return v;
    endfunction

    task automatic applyStimulus(input logic [4:0] a, input logic [31:0] din,
                                 input logic we, input logic [31:0] pc,
                                 input logic [4:0] exc, input logic bd,
                                 input logic eret, input logic [5:0] hw);
        bus.a         = a;
        bus.din       = din;
        bus.we        = we;
        bus.M_pc      = pc;
        bus.M_exccode = exc;
        bus.bd        = bd;
        bus.eret      = eret;
        bus.hwint     = hw;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    function automatic logic model_int();
        return ((bus.hwint & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_req();
        return reset && (model_int() || ((bus.M_exccode != 5'd0) && !m_sr[1]));
    endfunction

    function automatic logic [31:0] model_dout();
        case (bus.a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID_VAL;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_epc_out();
        if (bus.we && bus.a == 5'd14 && !model_req())
            return bus.din & ~32'h3;
        return m_epc;
    endfunction

    // Register updates at a clock edge, expressed on whole 32-bit words.
    task automatic model_step();
        logic        take;
        logic [31:0] code;
        logic        bd_eff;
        take   = model_req();
        code   = model_int() ? 32'd0 : {27'd0, bus.M_exccode};
        bd_eff = BD_ON && bus.bd;
        m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, bus.hwint} << 10);
        if (take) begin
            m_sr    = m_sr | 32'h2;
            m_cause = (m_cause & ~32'h8000_007C) | (code << 2)
                      | (bd_eff ? 32'h8000_0000 : 32'h0);
            m_epc   = (bus.M_pc - (bd_eff ? 32'd4 : 32'd0)) & ~32'h3;
        end else begin
            if (bus.we && bus.a == 5'd12) m_sr  = bus.din & 32'h0000_FC03;
            if (bus.we && bus.a == 5'd14) m_epc = bus.din & ~32'h3;
            if (bus.eret)                 m_sr  = m_sr & ~32'h2;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_sr = 0; m_cause = 0; m_epc = 0;

        //            a    din           we  pc           exc bd er hw    req dout          epc_out
        vecs[0]  = mk(12, 32'h0,        0, 32'h0,      0,  0, 0, 6'h0, 0, 32'h0,         32'h0);
        vecs[1]  = mk(13, 32'h0,        0, 32'h0,      0,  0, 0, 6'h0, 0, 32'h0,         32'h0);
        vecs[2]  = mk(12, 32'h0,        0, 32'h3008,   10, 0, 0, 6'h0, 1, 32'h0,         32'h0);
        vecs[3]  = mk(12, 32'h0,        0, 32'h3008,   10, 0, 0, 6'h0, 0, 32'h2,         32'h3008);
        vecs[4]  = mk(13, 32'h0,        0, 32'h0,      0,  0, 0, 6'h0, 0, 32'h28,        32'h3008);
        vecs[5]  = mk(14, 32'h0,        0, 32'h0,      0,  0, 0, 6'h0, 0, 32'h3008,      32'h3008);
        vecs[6]  = mk(12, 32'h0,        0, 32'h0,      0,  0, 1, 6'h0, 0, 32'h2,         32'h3008);
        vecs[7]  = mk(12, 32'h401,      1, 32'h0,      0,  0, 0, 6'h0, 0, 32'h0,         32'h3008);
        vecs[8]  = mk(12, 32'h0,        0, 32'h3010,   4,  0, 0, 6'h1, 1, 32'h401,       32'h3008);
        vecs[9]  = mk(13, 32'h0,        0, 32'h0,      0,  0, 0, 6'h0, 0, 32'h400,       32'h3010);
        vecs[10] = mk(12, 32'h0,        0, 32'h0,      0,  0, 0, 6'h0, 0, 32'h403,       32'h3010);
        vecs[11] = mk(14, 32'h0,        0, 32'h0,      0,  0, 1, 6'h0, 0, 32'h3010,      32'h3010);
        vecs[12] = mk(12, 32'h0,        0, 32'h3020,   12, 1, 0, 6'h0, 1, 32'h401,       32'h3010);
        vecs[13] = mk(14, 32'h0,        0, 32'h0,      0,  0, 0, 6'h0, 0, EPC_DS,        EPC_DS);
        vecs[14] = mk(13, 32'h0,        0, 32'h0,      0,  0, 0, 6'h0, 0, CAUSE_DS,      EPC_DS);
        vecs[15] = mk(12, 32'h0,        0, 32'h0,      0,  0, 1, 6'h0, 0, 32'h403,       EPC_DS);
        vecs[16] = mk(12, 32'h0,        1, 32'h3100,   5,  0, 0, 6'h0, 1, 32'h401,       EPC_DS);
        vecs[17] = mk(12, 32'h0,        0, 32'h0,      0,  0, 0, 6'h0, 0, 32'h403,       32'h3100);
        vecs[18] = mk(14, 32'h3043,     1, 32'h0,      0,  0, 0, 6'h0, 0, 32'h3100,      32'h3040);
        vecs[19] = mk(14, 32'h0,        0, 32'h0,      0,  0, 1, 6'h0, 0, 32'h3040,      32'h3040);
        vecs[20] = mk(12, 32'h0,        0, 32'h0,      0,  0, 0, 6'h0, 0, 32'h401,       32'h3040);
        vecs[21] = mk(12, 32'h403,      1, 32'h0,      0,  0, 1, 6'h0, 0, 32'h401,       32'h3040);
        vecs[22] = mk(12, 32'h0,        0, 32'h0,      0,  0, 0, 6'h0, 0, 32'h401,       32'h3040);
        vecs[23] = mk(15, 32'h0,        0, 32'h0,      0,  0, 0, 6'h0, 0, PRID_VAL,      32'h3040);
        vecs[24] = mk(3,  32'hFFFFFFFF, 1, 32'h0,      0,  0, 0, 6'h0, 0, 32'h0,         32'h3040);
        vecs[25] = mk(13, 32'hFFFFFFFF, 1, 32'h0,      0,  0, 0, 6'h0, 0, 32'h14,        32'h3040);
        vecs[26] = mk(13, 32'h0,        0, 32'h0,      0,  0, 0, 6'h0, 0, 32'h14,        32'h3040);

        // Reset held low with every interrupt line and an exception code up.
        reset = 1'b0;
        applyStimulus(12, 32'h0, 0, 32'h3000, 7, 0, 0, 6'h3F);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req", {31'd0, bus.req}, 32'h0);
        checkOutput("rst_sr", bus.dout, 32'h0);
        bus.a = 13; #1;
        checkOutput("rst_cause", bus.dout, 32'h0);
        bus.a = 14; #1;
        checkOutput("rst_epc", bus.dout, 32'h0);
        bus.a = 15; #1;
        checkOutput("rst_prid", bus.dout, PRID_VAL);
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 0, 6'h0);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Directed vector table.
        for (int i = 0; i < 27; i++) begin
            applyStimulus(vecs[i].a, vecs[i].din, vecs[i].we, vecs[i].pc,
                          vecs[i].exc, vecs[i].bd, vecs[i].eret, vecs[i].hwint);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_req", i), {31'd0, bus.req}, {31'd0, vecs[i].exp_req});
            checkOutput($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
            checkOutput($sformatf("vec%0d_epc_out", i), bus.epc_out, vecs[i].exp_epc);
            @(posedge clk); #1;
        end

        // Async reset in the middle of a handler.
        applyStimulus(12, 32'h0, 0, 32'h5000, 9, 0, 0, 6'h0);
        @(negedge clk);
        checkOutput("mid_take_req", {31'd0, bus.req}, 32'h1);
        @(posedge clk); #1;
        checkOutput("mid_exl_set", bus.dout, 32'h403);
        reset = 1'b0; #1;
        checkOutput("mid_rst_sr", bus.dout, 32'h0);
        checkOutput("mid_rst_req", {31'd0, bus.req}, 32'h0);
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 0, 6'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        m_sr = 0; m_cause = 0; m_epc = 0;

        // Randomized traffic against the word-level model.
        for (int i = 0; i < 600; i++) begin
            logic [4:0]  ra;
            logic [31:0] rdin;
            logic        rreq;
            logic [31:0] rdout;
            logic [31:0] repc;
            ra   = ($urandom_range(0, 4) != 0) ? 5'(12 + $urandom_range(0, 3))
                                               : 5'($urandom_range(0, 31));
            rdin = $urandom();
            if ($urandom_range(0, 1) == 0) rdin[1] = 1'b0;
            applyStimulus(ra, rdin, ($urandom_range(0, 3) == 0), $urandom(),
                          ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 2) == 0) ? 6'($urandom()) : 6'd0);
            rreq  = model_req();
            rdout = model_dout();
            repc  = model_epc_out();
            @(negedge clk);
            checkOutput($sformatf("rnd%0d_req", i), {31'd0, bus.req}, {31'd0, rreq});
            checkOutput($sformatf("rnd%0d_dout", i), bus.dout, rdout);
            checkOutput($sformatf("rnd%0d_epc_out", i), bus.epc_out, repc);
            @(posedge clk);
            model_step();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
